// File: rtl/clk_div_pkg.sv
// Shared defaults for the divider bank and its channels.
package clk_div_pkg;
  localparam int NCH_DEF     = 4;
  localparam int DW_DEF      = 8;
  localparam int DEF_DIV_DEF = 2;
  localparam int MIN_DIV     = 2;
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: modulo-N counter, shadow divisor, registered clk_out/tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [DW-1:0] wr_val,
  output logic          busy,
  output logic          ack,
  output logic          clk_out,
  output logic          tick
);
  logic [DW-1:0] cnt, n, shadow;
  logic [DW-1:0] cnt_nx, n_nx, sh_nx, val_c, half_nx;
  logic          run, wrap, load0, busy_nx, ack_nx;

  always_comb begin
    val_c   = (wr_val < DW'(MIN_DIV)) ? DW'(MIN_DIV) : wr_val;
    wrap    = run && (cnt == n - DW'(1));
    // A period starts fresh on wrap, sync or the first enabled edge;
    // only then may a new divisor take effect, so no runt period appears.
    load0   = !run || sync || wrap;
    cnt_nx  = cnt + DW'(1);
    n_nx    = n;
    sh_nx   = wr ? val_c : shadow;
    busy_nx = busy | wr;
    ack_nx  = 1'b0;
    if (!en) begin
      cnt_nx = '0;
      if (!wr && busy) begin
        n_nx    = shadow;
        busy_nx = 1'b0;
        ack_nx  = 1'b1;
      end
    end else if (load0) begin
      cnt_nx = '0;
      if (wr || busy) begin
        n_nx    = sh_nx;
        busy_nx = 1'b0;
        ack_nx  = 1'b1;
      end
    end
    half_nx = (n_nx >> 1) + {{(DW-1){1'b0}}, n_nx[0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      n       <= DW'(DEF_DIV);
      shadow  <= DW'(DEF_DIV);
      busy    <= 1'b0;
      ack     <= 1'b0;
      run     <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      n       <= n_nx;
      shadow  <= sh_nx;
      busy    <= busy_nx;
      ack     <= ack_nx;
      run     <= en;
      clk_out <= en && (cnt_nx < half_nx);
      tick    <= en && (cnt_nx == '0);
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers with shadowed divisor updates.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NCH     = NCH_DEF,
  parameter int  DW      = DW_DEF,
  parameter int  DEF_DIV = DEF_DIV_DEF,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           sync_all,
  input  logic           div_wr,
  input  logic [SW-1:0]  div_sel,
  input  logic [DW-1:0]  div_val,
  output logic [NCH-1:0] div_busy,
  output logic [NCH-1:0] div_ack,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);
  logic [NCH-1:0] sel_hit;

  // Out-of-range selects match no channel and are dropped.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NCH; i++)
      sel_hit[i] = div_wr && (int'(div_sel) == i);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(.DW(DW), .DEF_DIV(DEF_DIV)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .sync    (sync_all),
      .wr      (sel_hit[g]),
      .wr_val  (div_val),
      .busy    (div_busy[g]),
      .ack     (div_ack[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized and directed bench for clk_div_bank against a per-channel period model.
module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int DEF = 2;
  localparam int SW  = 2;

  logic           clk = 1'b0, reset = 1'b0, en = 1'b0, sync_all = 1'b0, div_wr = 1'b0;
  logic [SW-1:0]  div_sel = '0;
  logic [DW-1:0]  div_val = '0;
  logic [NCH-1:0] div_busy, div_ack, clk_out, tick;

  always #5 clk = ~clk;

  clk_div_bank #(.NCH(NCH), .DW(DW), .DEF_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .en(en), .sync_all(sync_all), .div_wr(div_wr),
    .div_sel(div_sel), .div_val(div_val), .div_busy(div_busy), .div_ack(div_ack),
    .clk_out(clk_out), .tick(tick)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;

  // Model state: position within the current period, active/pending divisors.
  int m_n[NCH], m_pend[NCH], m_pos[NCH];
  bit m_has_pend[NCH], m_run[NCH], m_ack[NCH], m_co[NCH], m_tk[NCH];
  int per_exp[NCH], last_tk[NCH];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  function automatic void model_edge(bit r, bit e, bit s, bit w, int sel, int val);
    for (int c = 0; c < NCH; c++) begin
      bit hit = w && (sel == c);
      int v = (val < 2) ? 2 : val;
      m_ack[c] = 0;
      if (!r) begin
        m_n[c] = DEF; m_pend[c] = DEF; m_has_pend[c] = 0; m_pos[c] = 0; m_run[c] = 0;
        m_co[c] = 0; m_tk[c] = 0;
      end else if (!e) begin
        m_pos[c] = 0; m_run[c] = 0; m_co[c] = 0; m_tk[c] = 0;
        if (hit) begin m_pend[c] = v; m_has_pend[c] = 1; end
        else if (m_has_pend[c]) begin m_n[c] = m_pend[c]; m_has_pend[c] = 0; m_ack[c] = 1; end
      end else begin
        if (!m_run[c] || s || m_pos[c] == m_n[c] - 1) begin
          m_pos[c] = 0;
          if (hit) begin m_n[c] = v; m_has_pend[c] = 0; m_ack[c] = 1; end
          else if (m_has_pend[c]) begin m_n[c] = m_pend[c]; m_has_pend[c] = 0; m_ack[c] = 1; end
        end else begin
          m_pos[c]++;
          if (hit) begin m_pend[c] = v; m_has_pend[c] = 1; end
        end
        m_run[c] = 1;
        m_co[c] = m_pos[c] < (m_n[c] + 1) / 2;
        m_tk[c] = m_pos[c] == 0;
      end
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit s, input bit w,
                      input int sel, input int val);
    logic [NCH-1:0] ec, et, eb, ea;
    reset = r; en = e; sync_all = s; div_wr = w; div_sel = SW'(sel); div_val = DW'(val);
    @(posedge clk);
    model_edge(r, e, s, w, sel, val);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = m_co[c]; et[c] = m_tk[c]; eb[c] = m_has_pend[c]; ea[c] = m_ack[c];
    end
    check("clk_out", int'(clk_out), int'(ec));
    check("tick", int'(tick), int'(et));
    check("div_busy", int'(div_busy), int'(eb));
    check("div_ack", int'(div_ack), int'(ea));
    for (int c = 0; c < NCH; c++)
      if (tick[c]) begin
        if (per_exp[c] > 0 && last_tk[c] >= 0)
          check($sformatf("period_ch%0d", c), cyc - last_tk[c], per_exp[c]);
        last_tk[c] = cyc;
      end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  task automatic watch_period(input int c, input int p);
    per_exp[c] = p; last_tk[c] = -1;
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin per_exp[c] = 0; last_tk[c] = -1; end
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 7);
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_busy", int'(div_busy), 0);

    // Default divide-by-2, all channels in phase from the first enabled edge.
    step(1, 1, 0, 0, 0, 0);
    check("start_tick_all", int'(tick), 7);
    check("start_clk_all", int'(clk_out), 7);
    watch_period(0, 2);
    idle(9);
    per_exp[0] = 0;

    // Divide-by-5 on channel 1 written mid-period.
    idle(1);
    step(1, 1, 0, 1, 1, 5);
    idle(4);
    watch_period(1, 5);
    idle(20);
    per_exp[1] = 0;

    // Back-to-back writes to channel 2: last write wins.
    step(1, 1, 0, 1, 2, 3);
    step(1, 1, 0, 1, 2, 7);
    idle(3);
    watch_period(2, 7);
    idle(25);
    per_exp[2] = 0;

    // N=3 and N=4, then phase-align with sync_all.
    step(1, 1, 0, 1, 0, 3);
    step(1, 1, 0, 1, 1, 4);
    idle(6);
    step(1, 1, 1, 0, 0, 0);
    check("sync_tick", int'(tick[1:0]), 3);
    check("sync_clk", int'(clk_out[1:0]), 3);
    idle(30);

    // en low: outputs quiet, immediate application, clamping of 0 to 2.
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("en0_ack", int'(div_ack[0]), 1);
    step(1, 1, 0, 0, 0, 0);
    watch_period(0, 2);
    idle(8);
    per_exp[0] = 0;

    // Out-of-range select is ignored.
    step(1, 1, 0, 1, 3, 9);
    idle(4);

    // Reset with a pending write loses the write.
    step(1, 1, 0, 1, 2, 40);
    step(0, 1, 0, 0, 0, 0);
    check("rst_busy", int'(div_busy), 0);
    idle(12);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      bit r = ($urandom_range(0, 99) != 0);
      bit e = ($urandom_range(0, 9) != 0);
      bit s = ($urandom_range(0, 19) == 0);
      bit w = ($urandom_range(0, 5) == 0);
      int sel = $urandom_range(0, 3);
      int val = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      step(r, e, s, w, sel, val);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter DW, default 8: divisor and counter width per channel.
REQ-003 Parameter DEF_DIV, default 2: divisor loaded into every channel at reset.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 Port en, input, 1 bit: global run enable; low halts and clears all channels.
REQ-008 Port sync_all, input, 1 bit: single-cycle pulse that restarts all channels phase-aligned.
REQ-009 Port div_wr, input, 1 bit: divisor write strobe.
REQ-010 Port div_sel, input, $clog2(NCH) bits (minimum 1): target channel for div_wr.
REQ-011 Port div_val, input, DW bits: new divisor N for the selected channel.
REQ-012 Port div_busy, output, NCH bits: per channel, a written divisor is pending and not yet applied.
REQ-013 Port div_ack, output, NCH bits: per channel, one-cycle pulse on the cycle a pending divisor becomes active.
REQ-014 Port clk_out, output, NCH bits: registered divided clock per channel.
REQ-015 Port tick, output, NCH bits: one-cycle enable pulse per channel, coincident with each clk_out rising edge.

Function
REQ-016 Each channel SHALL hold an active divisor N, a counter cnt (0..N-1) and a shadow divisor; counting is modulo N while en=1.
REQ-017 Divisor values below 2 SHALL be clamped to 2 when they are written.
REQ-018 clk_out SHALL be 1 when cnt < ceil(N/2), otherwise 0.
- N=2: 1 high, 1 low.
- N=5: 3 high, 2 low.
REQ-019 tick SHALL be 1 exactly when cnt = 0; with en held high, the tick period is N cycles.
REQ-020 clk_out, tick and cnt SHALL be registers updated on the same edge; outputs reflect the new cnt value with no combinational path from any input.
REQ-021 en=0 SHALL hold every cnt at 0 and drive clk_out=0 and tick=0.
- On the first edge with en=1, all channels load cnt=0, giving clk_out=1 and tick=1 in the same cycle for every channel.
REQ-022 A div_wr SHALL load the shadow divisor of channel div_sel and set div_busy for that channel on the next edge.
- A div_sel value >= NCH is ignored.
REQ-023 A pending shadow SHALL become active on the edge where cnt wraps from N-1 to 0. That edge also produces div_ack=1 and div_busy=0.
- No shortened or stretched period may be produced.
REQ-024 A div_wr to a channel that is already busy SHALL overwrite its shadow (last write wins); div_busy stays 1 and only one div_ack is issued.
REQ-025 If en=0, a pending shadow SHALL be applied on the edge after the write, with a div_ack pulse.
REQ-026 sync_all=1 with en=1 SHALL, on the next edge, force every cnt to 0 and apply every pending shadow, pulsing div_ack for those channels.
- A div_wr in the same cycle as sync_all is included in this application.
REQ-027 A div_wr in the same cycle as that channel's wrap edge SHALL be applied at that wrap; the old shadow is discarded.
REQ-028 Counter arithmetic SHALL be unsigned DW-bit; N up to 2^DW-1 SHALL be supported with no overflow.

Reset
REQ-029 While reset=0 on a clk edge, every channel SHALL load the following: cnt=0, N=DEF_DIV, shadow=DEF_DIV, clk_out=0, tick=0, div_busy=0, div_ack=0.
REQ-030 Reset SHALL take precedence over en, sync_all and div_wr; a write in flight during reset is discarded.
REQ-031 After reset is released with en=1, channels SHALL start as specified in REQ-021.

Structure
REQ-032 Shared package clk_div_pkg SHALL hold the default values of NCH, DW and DEF_DIV, plus the constant MIN_DIV=2.
REQ-033 A single sub-module, clk_div_chan, SHALL implement one channel (counter, shadow, outputs); clk_div_bank instantiates NCH copies and decodes div_sel.

Verification
REQ-034 Reset with en=1 and DEF_DIV=2 -> every clk_out toggles every cycle, tick on alternate cycles, and all channels are in phase.
REQ-035 Write N=5 to channel 1 mid-period -> div_busy[1]=1 until the next wrap; div_ack[1] pulses once; clk_out[1] is then 3 high, 2 low; no runt period appears.
REQ-036 Write N=3 and then N=7 to channel 2 before its wrap -> one div_ack; period becomes 7, never 3.
REQ-037 Channels set to N=3 and N=4, then sync_all pulsed -> the next cycle both channels show tick=1 and clk_out=1; common ticks recur every 12 cycles.
REQ-038 Drop en mid-count, write N=0 to channel 0, then raise en -> outputs are 0 while en=0, div_ack is immediate, and N is clamped to 2.
REQ-039 Assert reset mid-operation with a write pending -> all outputs reach their reset values on the next edge, and the pending divisor is lost.
